// File: rtl/psram_arb3.sv
// Three-port PSRAM access arbiter: video (port 0) has priority bounded by a
// starvation counter, picoBlaze (port 1) and DMA (port 2) share round-robin.
module psram_arb3 #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic        p0_burst,
    input  logic [22:0] p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic        p0_ub,
    input  logic        p0_lb,
    output logic        p0_grant,
    output logic        p0_op_begun,
    output logic        p0_data_ok,
    output logic        p0_op_finished,

    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic        p1_burst,
    input  logic [22:0] p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic        p1_ub,
    input  logic        p1_lb,
    output logic        p1_grant,
    output logic        p1_op_begun,
    output logic        p1_data_ok,
    output logic        p1_op_finished,

    input  logic        p2_req,
    input  logic        p2_wr,
    input  logic        p2_burst,
    input  logic [22:0] p2_addr,
    input  logic [15:0] p2_wdata,
    input  logic        p2_ub,
    input  logic        p2_lb,
    output logic        p2_grant,
    output logic        p2_op_begun,
    output logic        p2_data_ok,
    output logic        p2_op_finished,

    input  logic        ctrlr_good,
    input  logic        op_begun,
    input  logic        data_ok,
    input  logic        op_finished,

    output logic [22:0] app_addr,
    output logic [15:0] app_data_out,
    output logic        app_wr,
    output logic        app_rd,
    output logic        app_ub,
    output logic        app_lb,
    output logic        app_burst
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_gnt_idx;
    logic [3:0]  r_starve;
    logic        r_rr_p2;

    logic [22:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;
    logic        r_ub;
    logic        r_lb;
    logic        r_burst;

    logic        w_start;
    logic        w_end;
    logic        w_begun;
    logic        w_finished;
    logic        w_data_ok;
    logic [1:0]  w_win;

    logic [22:0] w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic        w_sel_wr;
    logic        w_sel_ub;
    logic        w_sel_lb;
    logic        w_sel_burst;

    assign w_start    = (r_state == ST_IDLE) && ctrlr_good && (p0_req || p1_req || p2_req);
    assign w_end      = (r_state != ST_IDLE) && (w_next == ST_IDLE);
    assign w_begun    = (r_state == ST_ISSUE) && op_begun;
    assign w_finished = ((r_state == ST_BUSY) && op_finished) || (w_begun && op_finished);
    assign w_data_ok  = (r_state == ST_BUSY) && data_ok;

    // Video wins unless it has starved the others for MAX_WAIT grants in a row.
    always_comb begin
        w_win = 2'd0;
        if (p0_req && (r_starve < LP_MAX_WAIT)) begin
            w_win = 2'd0;
        end else if (p1_req && p2_req) begin
            w_win = r_rr_p2 ? 2'd2 : 2'd1;
        end else if (p1_req) begin
            w_win = 2'd1;
        end else if (p2_req) begin
            w_win = 2'd2;
        end
    end

    always_comb begin
        w_sel_addr  = p0_addr;
        w_sel_wdata = p0_wdata;
        w_sel_wr    = p0_wr;
        w_sel_ub    = p0_ub;
        w_sel_lb    = p0_lb;
        w_sel_burst = p0_burst;
        case (w_win)
            2'd1: begin
                w_sel_addr  = p1_addr;
                w_sel_wdata = p1_wdata;
                w_sel_wr    = p1_wr;
                w_sel_ub    = p1_ub;
                w_sel_lb    = p1_lb;
                w_sel_burst = p1_burst;
            end
            2'd2: begin
                w_sel_addr  = p2_addr;
                w_sel_wdata = p2_wdata;
                w_sel_wr    = p2_wr;
                w_sel_ub    = p2_ub;
                w_sel_lb    = p2_lb;
                w_sel_burst = p2_burst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_begun) begin
                    w_next = op_finished ? ST_IDLE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (op_finished) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant and status pulses are decoded from state, so reset clears them at once.
    always_comb begin
        p0_grant       = 1'b0;
        p0_op_begun    = 1'b0;
        p0_data_ok     = 1'b0;
        p0_op_finished = 1'b0;
        p1_grant       = 1'b0;
        p1_op_begun    = 1'b0;
        p1_data_ok     = 1'b0;
        p1_op_finished = 1'b0;
        p2_grant       = 1'b0;
        p2_op_begun    = 1'b0;
        p2_data_ok     = 1'b0;
        p2_op_finished = 1'b0;
        app_wr         = (r_state == ST_ISSUE) && r_wr;
        app_rd         = (r_state == ST_ISSUE) && !r_wr;
        if (r_state != ST_IDLE) begin
            case (r_gnt_idx)
                2'd0: begin
                    p0_grant       = 1'b1;
                    p0_op_begun    = w_begun;
                    p0_data_ok     = w_data_ok;
                    p0_op_finished = w_finished;
                end
                2'd1: begin
                    p1_grant       = 1'b1;
                    p1_op_begun    = w_begun;
                    p1_data_ok     = w_data_ok;
                    p1_op_finished = w_finished;
                end
                2'd2: begin
                    p2_grant       = 1'b1;
                    p2_op_begun    = w_begun;
                    p2_data_ok     = w_data_ok;
                    p2_op_finished = w_finished;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_idx <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            r_ub      <= 1'b0;
            r_lb      <= 1'b0;
            r_burst   <= 1'b0;
        end else if (w_start) begin
            r_gnt_idx <= w_win;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_wr      <= w_sel_wr;
            r_ub      <= w_sel_ub;
            r_lb      <= w_sel_lb;
            r_burst   <= w_sel_burst;
        end else if (w_end) begin
            r_gnt_idx <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            r_ub      <= 1'b0;
            r_lb      <= 1'b0;
            r_burst   <= 1'b0;
        end
    end

    // Starvation only accrues when video wins while someone else is waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= 4'd0;
            r_rr_p2  <= 1'b0;
        end else if (w_start) begin
            if (w_win == 2'd0) begin
                if ((p1_req || p2_req) && (r_starve < LP_MAX_WAIT)) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else begin
                r_starve <= 4'd0;
                r_rr_p2  <= (w_win == 2'd1);
            end
        end
    end

    assign app_addr     = r_addr;
    assign app_data_out = r_wdata;
    assign app_ub       = r_ub;
    assign app_lb       = r_lb;
    assign app_burst    = r_burst;

endmodule

// File: tb/tb_psram_arb3.sv
// Randomized bench for psram_arb3: a transaction-level reference model predicts
// grants, controller strobes and per-port status every cycle.
module tb_psram_arb3;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  wr = '0;
    logic [2:0]  burst = '0;
    logic [2:0]  ub = '0;
    logic [2:0]  lb = '0;
    logic [22:0] addr [3];
    logic [15:0] wdata [3];
    logic        ctrlrGood = 1'b0;
    logic        opBegun = 1'b0;
    logic        dataOk = 1'b0;
    logic        opFinished = 1'b0;

    wire [2:0]   grant;
    wire [2:0]   opBegunO;
    wire [2:0]   dataOkO;
    wire [2:0]   opFinO;
    wire [22:0]  appAddr;
    wire [15:0]  appData;
    wire         appWr;
    wire         appRd;
    wire         appUb;
    wire         appLb;
    wire         appBurst;

    int total = 0;
    int bad = 0;

    bit          mInTxn;
    bit          mIssue;
    int          mPort;
    int          mStarve;
    int          mRrNext;
    logic [22:0] mAddr;
    logic [15:0] mData;
    bit          mWr;
    bit          mUb;
    bit          mLb;
    bit          mBurst;

    int          grantLog[$];
    logic [2:0]  prevGrant = '0;

    always #5 clk = ~clk;

    psram_arb3 #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(req[0]), .p0_wr(wr[0]), .p0_burst(burst[0]), .p0_addr(addr[0]),
        .p0_wdata(wdata[0]), .p0_ub(ub[0]), .p0_lb(lb[0]),
        .p0_grant(grant[0]), .p0_op_begun(opBegunO[0]), .p0_data_ok(dataOkO[0]),
        .p0_op_finished(opFinO[0]),
        .p1_req(req[1]), .p1_wr(wr[1]), .p1_burst(burst[1]), .p1_addr(addr[1]),
        .p1_wdata(wdata[1]), .p1_ub(ub[1]), .p1_lb(lb[1]),
        .p1_grant(grant[1]), .p1_op_begun(opBegunO[1]), .p1_data_ok(dataOkO[1]),
        .p1_op_finished(opFinO[1]),
        .p2_req(req[2]), .p2_wr(wr[2]), .p2_burst(burst[2]), .p2_addr(addr[2]),
        .p2_wdata(wdata[2]), .p2_ub(ub[2]), .p2_lb(lb[2]),
        .p2_grant(grant[2]), .p2_op_begun(opBegunO[2]), .p2_data_ok(dataOkO[2]),
        .p2_op_finished(opFinO[2]),
        .ctrlr_good(ctrlrGood), .op_begun(opBegun), .data_ok(dataOk),
        .op_finished(opFinished),
        .app_addr(appAddr), .app_data_out(appData), .app_wr(appWr), .app_rd(appRd),
        .app_ub(appUb), .app_lb(appLb), .app_burst(appBurst)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mInTxn  = 0;
        mIssue  = 0;
        mPort   = 0;
        mStarve = 0;
        mRrNext = 1;
        mAddr   = '0;
        mData   = '0;
        mWr     = 0;
        mUb     = 0;
        mLb     = 0;
        mBurst  = 0;
    endtask

    // Arbitration rules stated directly: bounded video priority, then fair 1/2.
    function automatic int pickWinner();
        if (req[0] && mStarve < MAX_WAIT) return 0;
        if (req[1] && req[2]) return mRrNext;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return 0;
    endfunction

    function automatic int oneHotToPort(input logic [2:0] v);
        if (v[0]) return 0;
        if (v[1]) return 1;
        return 2;
    endfunction

    task automatic checkAll();
        logic [2:0] eG, eB, eD, eF;
        eG = '0; eB = '0; eD = '0; eF = '0;
        if (mInTxn) begin
            eG[mPort] = 1'b1;
            if (mIssue && opBegun) eB[mPort] = 1'b1;
            if (!mIssue && dataOk) eD[mPort] = 1'b1;
            if ((mIssue && opBegun && opFinished) || (!mIssue && opFinished)) eF[mPort] = 1'b1;
        end
        checkOutput("grant", 32'(grant), 32'(eG));
        checkOutput("opBegun", 32'(opBegunO), 32'(eB));
        checkOutput("dataOk", 32'(dataOkO), 32'(eD));
        checkOutput("opFinished", 32'(opFinO), 32'(eF));
        checkOutput("appWr", 32'(appWr), 32'(mInTxn && mIssue && mWr));
        checkOutput("appRd", 32'(appRd), 32'(mInTxn && mIssue && !mWr));
        checkOutput("appAddr", 32'(appAddr), 32'(mAddr));
        checkOutput("appData", 32'(appData), 32'(mData));
        checkOutput("appUbLbBurst", 32'({appUb, appLb, appBurst}), 32'({mUb, mLb, mBurst}));
        if (grant != 3'b000 && prevGrant == 3'b000) grantLog.push_back(oneHotToPort(grant));
        prevGrant = grant;
    endtask

    task automatic endTxn();
        mInTxn = 0;
        mIssue = 0;
        mAddr  = '0;
        mData  = '0;
        mWr    = 0;
        mUb    = 0;
        mLb    = 0;
        mBurst = 0;
    endtask

    task automatic modelAdvance();
        int win;
        if (!mInTxn) begin
            if (ctrlrGood && req != 3'b000) begin
                win = pickWinner();
                if (win == 0) begin
                    if ((req[1] || req[2]) && mStarve < MAX_WAIT) mStarve++;
                end else begin
                    mStarve = 0;
                    mRrNext = (win == 1) ? 2 : 1;
                end
                mInTxn = 1;
                mIssue = 1;
                mPort  = win;
                mAddr  = addr[win];
                mData  = wdata[win];
                mWr    = wr[win];
                mUb    = ub[win];
                mLb    = lb[win];
                mBurst = burst[win];
            end
        end else if (mIssue) begin
            if (opBegun) begin
                if (opFinished) endTxn();
                else mIssue = 0;
            end
        end else if (opFinished) begin
            endTxn();
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkAll();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    // mode 0: fully random, 1: all request + fast controller,
    // 2: ports 1/2 only + fast controller, 3: controller not ready
    task automatic applyStimulus(input int mode);
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 23'($urandom());
            wdata[i] = 16'($urandom());
        end
        wr    = 3'($urandom());
        burst = 3'($urandom());
        ub    = 3'($urandom());
        lb    = 3'($urandom());
        dataOk = 1'($urandom());
        case (mode)
            1: begin
                req = 3'b111; ctrlrGood = 1; opBegun = 1; opFinished = 1;
            end
            2: begin
                req = 3'b110; ctrlrGood = 1; opBegun = 1; opFinished = 1;
            end
            3: begin
                req = 3'b001; ctrlrGood = 0; opBegun = 1; opFinished = 1;
            end
            default: begin
                req        = 3'($urandom());
                ctrlrGood  = ($urandom_range(0, 9) != 0);
                opBegun    = ($urandom_range(0, 9) < 4);
                opFinished = ($urandom_range(0, 9) < 3);
            end
        endcase
    endtask

    task automatic doReset();
        reset = 1'b0;
        #1;
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstAppStrobes", 32'({appWr, appRd}), 32'd0);
        checkOutput("rstAppAddr", 32'(appAddr), 32'd0);
        checkOutput("rstStatus", 32'({opBegunO, dataOkO, opFinO}), 32'd0);
        modelReset();
        prevGrant = '0;
        grantLog.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic checkOrder(input string tag, input int expected[$]);
        checkOutput({tag, "Len"}, 32'(grantLog.size() >= expected.size()), 32'd1);
        for (int k = 0; k < expected.size() && k < grantLog.size(); k++) begin
            checkOutput(tag, 32'(grantLog[k]), 32'(expected[k]));
        end
    endtask

    initial begin
        int expOrder[$];
        for (int i = 0; i < 3; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        #2;
        doReset();

        // Directed single read on port 1 and masked write on port 2.
        applyStimulus(0);
        req = 3'b010; wr[1] = 0; addr[1] = 23'h000123; ctrlrGood = 1;
        opBegun = 0; opFinished = 0; dataOk = 0;
        stepCycle();
        req = 3'b000;
        stepCycle();
        opBegun = 1;
        stepCycle();
        opBegun = 0; dataOk = 1;
        stepCycle();
        dataOk = 0; opFinished = 1;
        stepCycle();
        opFinished = 0;
        stepCycle();
        req = 3'b100; wr[2] = 1; ub[2] = 0; lb[2] = 1; wdata[2] = 16'hBEEF;
        stepCycle();
        req = 3'b000;
        stepCycle();
        opBegun = 1; opFinished = 1;
        stepCycle();
        opBegun = 0; opFinished = 0;
        stepCycle();

        // Contention: eight video grants, then port 1, eight more, then port 2.
        doReset();
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1);
            stepCycle();
        end
        expOrder.delete();
        for (int k = 0; k < 18; k++) expOrder.push_back((k == 8) ? 1 : ((k == 17) ? 2 : 0));
        checkOrder("contentionOrder", expOrder);

        // Ports 1 and 2 alternate when video is idle.
        doReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(2);
            stepCycle();
        end
        expOrder.delete();
        expOrder = '{1, 2, 1, 2};
        checkOrder("rrOrder", expOrder);

        // Controller not ready blocks grants; grant follows once it is ready.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(3);
            stepCycle();
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3);
            ctrlrGood = 1; opBegun = 0; opFinished = 0;
            stepCycle();
        end

        // Reset while port 2 is in BUSY.
        doReset();
        applyStimulus(0);
        req = 3'b100; ctrlrGood = 1; opBegun = 0; opFinished = 0; dataOk = 0;
        stepCycle();
        req = 3'b000; opBegun = 1;
        stepCycle();
        opBegun = 0; dataOk = 1;
        #1;
        checkOutput("busyDataOk", 32'(dataOkO), 32'h4);
        reset = 1'b0; opFinished = 1;
        #1;
        checkOutput("midRstGrant", 32'(grant), 32'd0);
        checkOutput("midRstStrobes", 32'({appWr, appRd}), 32'd0);
        checkOutput("midRstOpFin", 32'(opFinO), 32'd0);
        checkOutput("midRstDataOk", 32'(dataOkO), 32'd0);
        modelReset();
        prevGrant = '0;
        @(posedge clk);
        #1;
        reset = 1'b1; opFinished = 0; dataOk = 0;
        req = 3'b100;
        stepCycle();
        checkOutput("freshGrant", 32'(grant), 32'h4);
        req = 3'b000; opBegun = 1; opFinished = 1;
        stepCycle();

        // Long randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(0);
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
